// File: rtl/reloadable_up_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reloadable_up_counter_pkg
// Brief    : Shared state encoding and default width for the reload counter.
// Revision : 1.0 - initial release
// ============================================================================
package reloadable_up_counter_pkg;

  localparam int c_default_width = 8;

  // 2'd3 is unused and treated as a corrupted state that recovers to idle.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/reloadable_up_counter.sv
`default_nettype none
// ============================================================================
// Module   : reloadable_up_counter
// Brief    : Reloadable up counter with programmable terminal value,
//            one-shot / auto-reload modes and a registered terminal pulse.
// Revision : 1.0 - initial release
// ============================================================================
module reloadable_up_counter
  import reloadable_up_counter_pkg::*;
#(
  parameter int WIDTH = c_default_width
) (
  input  logic             CLK,
  input  logic             RESET_BTN,
  input  logic             START,
  input  logic             STOP,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] RELOAD_VAL,
  input  logic [WIDTH-1:0] TERM_VAL,
  input  logic             MODE,
  output logic [WIDTH-1:0] COUNT,
  output logic             TC,
  output logic             DONE,
  output logic             RUNNING,
  output logic             OVF
);

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_reload;
  logic             r_tc;
  logic             r_ovf;

  logic             w_at_term;
  logic             w_all_ones;

  assign w_at_term  = (r_count == TERM_VAL);
  assign w_all_ones = &r_count;

  // Reset arrives already synchronised upstream, so it is sampled here only.
  always_ff @(posedge CLK) begin
    if (!RESET_BTN) begin
      r_state  <= ST_IDLE;
      r_count  <= '0;
      r_reload <= '0;
      r_tc     <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (LOAD) begin
      r_reload <= RELOAD_VAL;
      r_count  <= RELOAD_VAL;
      r_ovf    <= 1'b0;
      r_tc     <= 1'b0;
      if (r_state != ST_RUN) begin
        r_state <= ST_IDLE;
      end
    end else begin
      case (r_state)
        ST_RUN: begin
          if (STOP) begin
            r_state <= ST_IDLE;
            r_tc    <= 1'b0;
          end else if (w_at_term) begin
            r_tc <= 1'b1;
            if (MODE) begin
              r_count <= r_reload;
            end else begin
              r_state <= ST_DONE;
            end
          end else begin
            r_count <= r_count + 1'b1;
            r_tc    <= 1'b0;
            if (w_all_ones) begin
              r_ovf <= 1'b1;
            end
          end
        end
        ST_IDLE: begin
          r_tc <= 1'b0;
          if (START && !STOP) begin
            r_state <= ST_RUN;
          end
        end
        ST_DONE: begin
          r_tc <= 1'b0;
          if (START && !STOP) begin
            r_state <= ST_RUN;
            r_count <= r_reload;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_tc    <= 1'b0;
        end
      endcase
    end
  end

  assign COUNT   = r_count;
  assign TC      = r_tc;
  assign OVF     = r_ovf;
  assign DONE    = (r_state == ST_DONE);
  assign RUNNING = (r_state == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_reloadable_up_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_reloadable_up_counter
// Brief    : Self-checking bench for reloadable_up_counter with a behavioural
//            reference model and randomized stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reloadable_up_counter;

  localparam int W    = 8;
  localparam int MODV = 1 << W;

  logic         CLK = 1'b0;
  logic         RESET_BTN;
  logic         START;
  logic         STOP;
  logic         LOAD;
  logic [W-1:0] RELOAD_VAL;
  logic [W-1:0] TERM_VAL;
  logic         MODE;
  logic [W-1:0] COUNT;
  logic         TC;
  logic         DONE;
  logic         RUNNING;
  logic         OVF;

  int checks   = 0;
  int failures = 0;

  // Reference model: counter value as an integer plus plain activity flags.
  int m_count;
  int m_reload;
  bit m_run;
  bit m_done;
  bit m_tc;
  bit m_ovf;

  logic [W+3:0] w_obs;
  logic [W+3:0] w_exp;

  reloadable_up_counter #(.WIDTH(W)) dut (
    .CLK        (CLK),
    .RESET_BTN  (RESET_BTN),
    .START      (START),
    .STOP       (STOP),
    .LOAD       (LOAD),
    .RELOAD_VAL (RELOAD_VAL),
    .TERM_VAL   (TERM_VAL),
    .MODE       (MODE),
    .COUNT      (COUNT),
    .TC         (TC),
    .DONE       (DONE),
    .RUNNING    (RUNNING),
    .OVF        (OVF)
  );

  always #5 CLK = ~CLK;

  always_comb begin
    w_obs = {COUNT, TC, DONE, RUNNING, OVF};
    w_exp = {m_count[W-1:0], m_tc, m_done, m_run, m_ovf};
  end

  function automatic void model_step();
    if (!RESET_BTN) begin
      m_count = 0; m_reload = 0; m_run = 0; m_done = 0; m_tc = 0; m_ovf = 0;
    end else if (LOAD) begin
      m_reload = RELOAD_VAL;
      m_count  = RELOAD_VAL;
      m_ovf    = 0;
      m_tc     = 0;
      m_done   = 0;
    end else if (m_run) begin
      if (STOP) begin
        m_run = 0;
        m_tc  = 0;
      end else if (m_count == int'(TERM_VAL)) begin
        m_tc = 1;
        if (MODE) m_count = m_reload;
        else begin
          m_run  = 0;
          m_done = 1;
        end
      end else begin
        m_tc = 0;
        if (m_count == MODV - 1) m_ovf = 1;
        m_count = (m_count + 1) % MODV;
      end
    end else begin
      m_tc = 0;
      if (START && !STOP) begin
        if (m_done) m_count = m_reload;
        m_done = 0;
        m_run  = 1;
      end
    end
  endfunction

  task automatic cycle();
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    START = 0; STOP = 0; LOAD = 0;
  endtask

  // Load a value and park the counter in idle with that value.
  task automatic load_and_park(input logic [W-1:0] rv, input logic [W-1:0] tv, input logic md);
    idle_inputs();
    RELOAD_VAL = rv; TERM_VAL = tv; MODE = md;
    LOAD = 1; cycle();
    LOAD = 0; STOP = 1; cycle();
    STOP = 0;
  endtask

  task automatic test_reset();
    RESET_BTN = 0; START = 1; LOAD = 1; STOP = 0;
    RELOAD_VAL = 8'hAA; TERM_VAL = 8'h10; MODE = 0;
    cycle(); cycle();
    checks++;
    if (w_obs !== '0) begin
      failures++;
      $display("FAIL reset_state: got count/tc/done/run/ovf=%h required 0", w_obs);
    end
    RESET_BTN = 1; LOAD = 0; START = 1;
    cycle();
    START = 0;
    checks++;
    if (RUNNING !== 1'b1 || COUNT !== 8'd0) begin
      failures++;
      $display("FAIL reset_start: got running=%b count=%0d required running=1 count=0", RUNNING, COUNT);
    end
  endtask

  task automatic test_one_shot();
    int exp_seq[4] = '{5, 6, 7, 8};
    int tc_seen = 0;
    load_and_park(8'd5, 8'd8, 1'b0);
    START = 1; cycle(); START = 0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (COUNT !== exp_seq[i][W-1:0] || RUNNING !== 1'b1) begin
        failures++;
        $display("FAIL one_shot_seq[%0d]: got count=%0d running=%b required count=%0d running=1", i, COUNT, RUNNING, exp_seq[i]);
      end
      if (i < 3) cycle();
    end
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (TC === 1'b1) tc_seen++;
      checks++;
      if (w_obs !== w_exp) begin
        failures++;
        $display("FAIL one_shot_tail[%0d]: got %h required %h", i, w_obs, w_exp);
      end
    end
    checks++;
    if (tc_seen != 1 || DONE !== 1'b1 || COUNT !== 8'd8) begin
      failures++;
      $display("FAIL one_shot_done: got tc_pulses=%0d done=%b count=%0d required 1 1 8", tc_seen, DONE, COUNT);
    end
    START = 1; cycle(); START = 0;
    checks++;
    if (COUNT !== 8'd5 || RUNNING !== 1'b1 || DONE !== 1'b0) begin
      failures++;
      $display("FAIL one_shot_restart: got count=%0d running=%b done=%b required 5 1 0", COUNT, RUNNING, DONE);
    end
  endtask

  task automatic test_auto_reload();
    int tc_cnt = 0;
    int bad    = 0;
    load_and_park(8'd250, 8'd253, 1'b1);
    START = 1; cycle(); START = 0;
    for (int i = 0; i < 16; i++) begin
      cycle();
      if (TC === 1'b1) tc_cnt++;
      if (COUNT !== 8'(250 + ((i + 1) % 4)) || DONE !== 1'b0 || OVF !== 1'b0) bad++;
      checks++;
      if (w_obs !== w_exp) begin
        failures++;
        $display("FAIL auto_reload_model[%0d]: got %h required %h", i, w_obs, w_exp);
      end
    end
    checks++;
    if (tc_cnt != 4 || bad != 0) begin
      failures++;
      $display("FAIL auto_reload_pattern: got tc_pulses=%0d bad_cycles=%0d required 4 0", tc_cnt, bad);
    end
  endtask

  task automatic test_wrap();
    load_and_park(8'd254, 8'd1, 1'b0);
    START = 1; cycle(); START = 0;
    cycle(); cycle();
    checks++;
    if (COUNT !== 8'd0 || OVF !== 1'b1) begin
      failures++;
      $display("FAIL wrap_ovf: got count=%0d ovf=%b required 0 1", COUNT, OVF);
    end
    cycle(); cycle();
    checks++;
    if (DONE !== 1'b1 || TC !== 1'b1 || COUNT !== 8'd1 || OVF !== 1'b1) begin
      failures++;
      $display("FAIL wrap_done: got done=%b tc=%b count=%0d ovf=%b required 1 1 1 1", DONE, TC, COUNT, OVF);
    end
    RELOAD_VAL = 8'd40; LOAD = 1; cycle(); LOAD = 0;
    checks++;
    if (OVF !== 1'b0 || DONE !== 1'b0 || RUNNING !== 1'b0 || COUNT !== 8'd40) begin
      failures++;
      $display("FAIL wrap_load_clear: got ovf=%b done=%b run=%b count=%0d required 0 0 0 40", OVF, DONE, RUNNING, COUNT);
    end
  endtask

  task automatic test_simultaneous();
    load_and_park(8'd10, 8'd12, 1'b1);
    START = 1; cycle(); START = 0;
    cycle(); cycle();
    RELOAD_VAL = 8'd77; LOAD = 1; STOP = 1; START = 1;
    cycle();
    checks++;
    if (COUNT !== 8'd77 || RUNNING !== 1'b1 || TC !== 1'b0) begin
      failures++;
      $display("FAIL load_wins: got count=%0d running=%b tc=%b required 77 1 0", COUNT, RUNNING, TC);
    end
    LOAD = 0;
    cycle();
    checks++;
    if (RUNNING !== 1'b0 || DONE !== 1'b0 || COUNT !== 8'd77) begin
      failures++;
      $display("FAIL stop_wins: got running=%b done=%b count=%0d required 0 0 77", RUNNING, DONE, COUNT);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_count();
    load_and_park(8'd95, 8'd200, 1'b0);
    START = 1; cycle(); START = 0;
    repeat (5) cycle();
    checks++;
    if (COUNT !== 8'd100) begin
      failures++;
      $display("FAIL mid_pre: got count=%0d required 100", COUNT);
    end
    RESET_BTN = 0; cycle(); RESET_BTN = 1;
    checks++;
    if (w_obs !== '0) begin
      failures++;
      $display("FAIL mid_reset: got %h required 0", w_obs);
    end
    TERM_VAL = 8'd3; MODE = 0;
    START = 1; cycle(); START = 0;
    repeat (4) cycle();
    checks++;
    if (DONE !== 1'b1 || COUNT !== 8'd3) begin
      failures++;
      $display("FAIL mid_run_done: got done=%b count=%0d required 1 3", DONE, COUNT);
    end
    START = 1; cycle(); START = 0;
    checks++;
    if (COUNT !== 8'd0 || RUNNING !== 1'b1) begin
      failures++;
      $display("FAIL mid_reload_cleared: got count=%0d running=%b required 0 1", COUNT, RUNNING);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      RESET_BTN  = ($urandom_range(0, 79) != 0);
      LOAD       = ($urandom_range(0, 15) == 0);
      START      = ($urandom_range(0, 3) == 0);
      STOP       = !START && ($urandom_range(0, 15) == 0);
      if (LOAD) RELOAD_VAL = W'($urandom);
      if ($urandom_range(0, 7) == 0) TERM_VAL = W'(m_reload + int'($urandom_range(0, 6)));
      if ($urandom_range(0, 15) == 0) MODE = ~MODE;
      cycle();
      checks++;
      if (w_obs !== w_exp) begin
        failures++;
        $display("FAIL random[%0d]: got count/tc/done/run/ovf=%h required %h", i, w_obs, w_exp);
      end
    end
    idle_inputs();
    RESET_BTN = 1;
  endtask

  initial begin
    RESET_BTN = 0; START = 0; STOP = 0; LOAD = 0;
    RELOAD_VAL = '0; TERM_VAL = '0; MODE = 0;
    m_count = 0; m_reload = 0; m_run = 0; m_done = 0; m_tc = 0; m_ovf = 0;
    #2;
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_wrap();
    test_simultaneous();
    test_reset_mid_count();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reloadable_up_counter.md
Name: reloadable_up_counter

Overview:
- Reloadable 8-bit up counter with a programmable terminal value, one-shot/auto-reload modes and a terminal-count pulse.
- Sits directly downstream of the reset synchroniser stage; its RESET_BTN input is driven by the synchroniser output, so reset arrives clean and is treated here as purely synchronous.
- Drives COUNT, TC and DONE to downstream display/control logic.

Parameters:
- WIDTH, 8, counter/reload/terminal data width in bits

Ports:
- CLK  input  1  system clock; all state updates on rising edge
- RESET_BTN  input  1  synchronous, active-low reset (driven from synchroniser output)
- START  input  1  level-sampled start request
- STOP  input  1  level-sampled stop request
- LOAD  input  1  load RELOAD_VAL into reload register and COUNT
- RELOAD_VAL  input  WIDTH  value captured on LOAD
- TERM_VAL  input  WIDTH  terminal value, compared live every cycle
- MODE  input  1  0 = one-shot, 1 = auto-reload
- COUNT  output  WIDTH  current count (registered)
- TC  output  1  one-cycle terminal-count pulse (registered)
- DONE  output  1  high while in DONE state
- RUNNING  output  1  high while in RUN state
- OVF  output  1  sticky: count wrapped from all-ones to 0

Behaviour:
- Reset: sampled only at a CLK rising edge with RESET_BTN=0. Results: COUNT=0, reload_reg=0, state=IDLE, TC=0, DONE=0, RUNNING=0, OVF=0. Reset has no asynchronous path. Reset mid-count aborts immediately, with no TC.
- States: IDLE, RUN, DONE. DONE and RUNNING are decoded directly from the state register.
- Per-edge priority: reset > LOAD > STOP > START > count.
- LOAD (any state):
  - reload_reg<=RELOAD_VAL; COUNT<=RELOAD_VAL; OVF<=0; TC<=0.
  - RUN stays RUN, IDLE stays IDLE, DONE goes to IDLE.
- STOP:
  - In RUN: go to IDLE, COUNT holds, TC<=0.
  - In IDLE/DONE: no effect.
- START:
  - In IDLE: go to RUN. COUNT does not increment on this edge.
  - In DONE: go to RUN with COUNT<=reload_reg.
  - In RUN: ignored.
- RUN, each edge with no higher-priority event:
  - If COUNT==TERM_VAL: TC<=1.
    - MODE=1: COUNT<=reload_reg, stay RUN.
    - MODE=0: COUNT holds, go to DONE.
  - Else: COUNT<=COUNT+1 modulo 2^WIDTH, TC<=0. If COUNT was all-ones, OVF<=1, i.e. wrap-around is legal and flagged when TERM_VAL < reload start.
- TC latency: TC is high in the cycle after the edge at which COUNT==TERM_VAL was observed, and lasts one cycle.
- Corner case: with MODE=1 and TERM_VAL==reload_reg, TC stays high every RUN cycle and COUNT is constant.
- Outside RUN: COUNT holds and TC=0.
- TERM_VAL or MODE changes take effect on the next compare; no shadowing.

Decomposition:
- Shared package holds:
  - State encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2; 2'd3 is illegal and recovers to IDLE.
  - Default WIDTH constant.
- Single flat module; no sub-module is warranted.

Test Plan:
1. Reset: hold RESET_BTN=0 for 2 edges while START=1 and LOAD=1 -> COUNT=0, all flags 0, state IDLE. Release, then START -> RUNNING=1 one edge later with COUNT still 0.
2. One-shot: LOAD RELOAD_VAL=8'd5, TERM_VAL=8'd8, MODE=0, START -> COUNT 5,6,7,8. TC=1 for exactly one cycle after 8 is seen; DONE=1; COUNT holds 8. A second START gives COUNT=5, RUNNING=1.
3. Auto-reload: RELOAD_VAL=8'd250, TERM_VAL=8'd253, MODE=1 -> COUNT 250..253,250..; TC pulses every 4 cycles; DONE stays 0; OVF stays 0.
4. Wrap: RELOAD_VAL=8'd254, TERM_VAL=8'd1, MODE=0 -> COUNT 254,255,0,1; OVF=1 from the edge 255->0; then DONE. A subsequent LOAD clears OVF.
5. Simultaneous events:
   - LOAD+STOP+START in RUN at COUNT==TERM_VAL -> LOAD wins: COUNT=RELOAD_VAL, state RUN, TC=0.
   - STOP+START in RUN -> IDLE.
6. Reset mid-count: RUN at COUNT=8'd100, assert RESET_BTN=0 for one edge -> next cycle COUNT=0, IDLE, TC=0, reload_reg=0.
